// File: rtl/m_ext_pkg.sv
// Shared types and constants for the RV32M divide unit.
package m_ext_pkg;

  typedef enum logic [2:0] {
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor magnitude.
module div_restoring_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_borrow;

  // rem < dvsr always holds, so the shifted partial remainder fits in XLEN+1 bits.
  assign w_shift  = {i_rem, i_quo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, i_dvsr};
  assign w_borrow = w_diff[XLEN];

  assign o_rem = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU; stalls the pipeline while iterating.
module iterative_divider
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            stall_pipl,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned    CW      = $clog2(XLEN);
  localparam logic [CW-1:0]  LP_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] LP_DBZ_Q =
    (XLEN == 32) ? XLEN'(DIV_BY_ZERO_Q) : {XLEN{1'b1}};
  localparam logic [XLEN-1:0] LP_OVF_Q =
    (XLEN == 32) ? XLEN'(DIV_OVF_Q) : {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      r_state, w_state_nxt;
  div_op_t         r_op, w_op_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [XLEN-1:0] r_rem, w_rem_nxt;
  logic [XLEN-1:0] r_quo, w_quo_nxt;
  logic [XLEN-1:0] r_dvsr, w_dvsr_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;
  logic            r_neg_q, w_neg_q_nxt;
  logic            r_neg_r, w_neg_r_nxt;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_dvz;
  logic            w_ovf;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_signed = ~fun3[0];
  assign w_a_neg  = w_signed & dividend[XLEN-1];
  assign w_b_neg  = w_signed & divisor[XLEN-1];
  assign w_a_abs  = w_a_neg ? (XLEN'(0) - dividend) : dividend;
  assign w_b_abs  = w_b_neg ? (XLEN'(0) - divisor) : divisor;
  assign w_dvz    = (divisor == '0);
  assign w_ovf    = w_signed & (dividend == LP_OVF_Q) & (divisor == '1);

  div_restoring_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_step_rem),
    .o_quo  (w_step_quo)
  );

  assign w_q_fix = r_neg_q ? (XLEN'(0) - w_step_quo) : w_step_quo;
  assign w_r_fix = r_neg_r ? (XLEN'(0) - w_step_rem) : w_step_rem;

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_count_nxt  = r_count;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvsr_nxt   = r_dvsr;
    w_result_nxt = r_result;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    stall_pipl   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start && !kill) begin
          stall_pipl  = 1'b1;
          w_op_nxt    = div_op_t'(fun3);
          w_neg_q_nxt = w_a_neg ^ w_b_neg;
          w_neg_r_nxt = w_a_neg;
          if (w_dvz) begin
            w_result_nxt = fun3[1] ? dividend : LP_DBZ_Q;
            w_state_nxt  = DONE;
          end else if (w_ovf) begin
            w_result_nxt = fun3[1] ? '0 : LP_OVF_Q;
            w_state_nxt  = DONE;
          end else begin
            w_rem_nxt   = '0;
            w_quo_nxt   = w_a_abs;
            w_dvsr_nxt  = w_b_abs;
            w_count_nxt = '0;
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        stall_pipl  = 1'b1;
        w_rem_nxt   = w_step_rem;
        w_quo_nxt   = w_step_quo;
        w_count_nxt = r_count + CW'(1);
        if (r_count == LP_LAST) begin
          w_result_nxt = r_op[1] ? w_r_fix : w_q_fix;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        // The instruction advances now; a start still seen here is the same instruction.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (kill) begin
      w_state_nxt  = IDLE;
      w_result_nxt = r_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_op     <= DIV;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_count  <= w_count_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dvsr   <= w_dvsr_nxt;
      r_result <= w_result_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
    end
  end

  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule
